oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Bus initiator for sprite DMA: CPU write to $4014 with page P copies bytes $PP00-$PPFF into PPU OAM.
//  Drives the synchronous CPU work-RAM/bus read port (ce/rnw/addr, 1-cycle read latency) and the OAM write port.
//  Stalls the CPU through o_rdy while active. Sits between the CPU register decode and the CPU RAM and PPU OAM.
// PARAMETERS
//  DMA_LEN   256  bytes per transfer; index counter is clog2(DMA_LEN) bits
//  ADDR_W    16   CPU bus address width
// PORTS
//  i_clk_cpu    in   1       CPU clock; the only clock
//  i_reset      in   1       asynchronous, active-high reset
//  i_trig       in   1       one-cycle pulse: CPU wrote $4014
//  i_page       in   8       source page, sampled when i_trig=1
//  i_oam_base   in   8       current OAMADDR, sampled when i_trig=1
//  o_rdy        out  1       1=CPU may run, 0=CPU halted
//  o_busy       out  1       1 while state!=IDLE
//  o_bus_ce     out  1       bus read enable
//  o_bus_rnw    out  1       always 1; DMA only reads the bus
//  o_bus_addr   out  ADDR_W  {page, idx}
//  i_bus_data   in   8       read data, valid 1 cycle after o_bus_ce
//  o_oam_we     out  1       OAM write strobe
//  o_oam_addr   out  8       OAM byte address
//  o_oam_data   out  8       OAM write data
//  i_abort      in   1       present only when OAM_DMA_ABORT_EN is defined
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, o_rdy=1, o_busy=0, o_bus_ce=0, o_bus_rnw=1, o_bus_addr=0,
//   o_oam_we=0, o_oam_addr=0, o_oam_data=0, idx=0, parity=0.
//  parity: 1-bit register, toggles every cycle from reset; 0=get cycle, 1=put cycle.
//  FSM: IDLE -> HALT -> [ALIGN] -> READ <-> WRITE -> IDLE. All outputs registered.
//  IDLE : i_trig=1 -> latch page/base, idx=0, go HALT. o_rdy=0 from the next cycle.
//  HALT : 1 cycle. Exit to ALIGN if parity==1 at that edge, else to READ.
//  ALIGN: 1 cycle dummy, no bus access. Then READ.
//  READ : o_bus_ce=1, o_bus_addr={page,idx}. Next state WRITE.
//  WRITE: o_oam_we=1, o_oam_data=i_bus_data (latched the previous cycle), o_oam_addr=base+idx (8-bit wrap).
//         o_bus_ce=0. If idx==DMA_LEN-1 -> IDLE, o_rdy=1. Otherwise idx++ and go READ.
//  Length: o_rdy low for 513 cycles (even start) or 514 (odd start). Exactly DMA_LEN OAM writes.
//  idx is 8 bits with no carry into page: source never crosses $PPFF. OAM address wraps $FF->$00.
//  i_trig while busy: ignored; no relatch, no restart.
//  i_trig in the same cycle the last WRITE completes: ignored. A new DMA needs i_trig while IDLE.
//  Reset mid-transfer: transfer dropped, o_rdy=1 at once, no more OAM writes.
// CONFIGURATION
//  OAM_DMA_ABORT_EN defined: i_abort port exists.
//   i_abort=1 in any non-IDLE state -> IDLE on that edge, o_rdy=1, o_busy=0, o_bus_ce=0, o_oam_we=0.
//   A WRITE in progress on that edge is suppressed.
//   i_abort has priority over i_trig and over normal completion.
//  Not defined: port absent; a transfer always runs to completion or reset.
// STRUCTURE
//  oam_dma_defs.vh holds: state encodings (IDLE, HALT, ALIGN, READ, WRITE) and OAM_DMA_REG_ADDR=16'h4014.
//  Single module; no sub-module. The FSM, idx counter and parity are too small to split.
// TESTING
//  1 Reset, fill RAM $0200-$02FF with i^8'hA5. Trigger page=8'h02, base=0, parity=0
//    -> 513 cycles o_rdy=0; OAM[i]=i^8'hA5; 256 writes.
//  2 Same, triggered with parity=1 -> ALIGN visited; o_rdy low exactly 514 cycles; data identical.
//  3 base=8'hFE, page=8'h03 -> first write OAM[$FE]=mem[$0300], then $FF, $00...;
//    last address $FD; o_bus_addr never exceeds 16'h03FF.
//  4 Second i_trig (page=8'h05) at cycle 100 of a transfer -> ignored;
//    all 256 reads still from page $02; o_busy one continuous pulse.
//  5 Assert i_reset at write #40 -> same cycle o_rdy=1 and o_oam_we=0; no writes after; IDLE.
//  6 (OAM_DMA_ABORT_EN) i_abort at idx=10 in WRITE -> that write suppressed;
//    OAM[0..9] written, OAM[10..] unchanged; o_rdy=1 next cycle.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the sprite-DMA controller: FSM state encodings and the
// CPU register address that launches a transfer.
package oam_dma_ctrl_pkg;

   // CPU write to this address with page P starts a $PP00-$PPFF copy into OAM.
   localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA bus initiator: halts the CPU, reads 256 bytes from page P over the
// CPU bus and writes them into PPU OAM starting at the latched OAMADDR.
// Optional feature macro: OAM_DMA_ABORT_EN (adds the i_abort port).
module oam_dma_ctrl
   import oam_dma_ctrl_pkg::*;
#(
   parameter int DMA_LEN = 256,
   parameter int ADDR_W  = 16
) (
   input  logic              i_clk_cpu,
   input  logic              i_reset,
   input  logic              i_trig,
   input  logic [7:0]        i_page,
   input  logic [7:0]        i_oam_base,
`ifdef OAM_DMA_ABORT_EN
   input  logic              i_abort,
`endif
   output logic              o_rdy,
   output logic              o_busy,
   output logic              o_bus_ce,
   output logic              o_bus_rnw,
   output logic [ADDR_W-1:0] o_bus_addr,
   input  logic [7:0]        i_bus_data,
   output logic              o_oam_we,
   output logic [7:0]        o_oam_addr,
   output logic [7:0]        o_oam_data
);

   localparam int IDX_W = $clog2(DMA_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                r_parity;
   logic [7:0]          r_page;
   logic [7:0]          r_base;
   logic                w_abort;

   logic                r_rdy;
   logic                r_busy;
   logic                r_bus_ce;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic                r_oam_we;
   logic [7:0]          r_oam_addr;
   logic [7:0]          r_oam_data;

`ifdef OAM_DMA_ABORT_EN
   assign w_abort = i_abort;
`else
   assign w_abort = 1'b0;
`endif

   // Get/put phase: 0 = get cycle, 1 = put cycle; free-running from reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, matching real flip-flops.
   always_ff @(posedge i_clk_cpu or posedge i_reset) begin
      if (i_reset) r_parity <= 1'b0;
      else         r_parity <= ~r_parity;
   end

   // Next-state and next-index decode.
   // NOTE: every combinational output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (i_trig) begin
               w_state_nxt = ST_HALT;
               w_idx_nxt   = '0;
            end
         end
         // READ has to land on a get cycle; HALT sits on a put cycle only
         // when the trigger was accepted on a get cycle.
         ST_HALT:  w_state_nxt = r_parity ? ST_READ : ST_ALIGN;
         ST_ALIGN: w_state_nxt = ST_READ;
         ST_READ:  w_state_nxt = ST_WRITE;
         ST_WRITE: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_READ;
               w_idx_nxt   = r_idx + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Abort beats trigger and completion; the write that would have been
      // launched on this edge never starts.
      if (w_abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
   end

   // State and byte-index registers.
   always_ff @(posedge i_clk_cpu or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Capture source page and OAM base only when a trigger is accepted.
   always_ff @(posedge i_clk_cpu or posedge i_reset) begin
      if (i_reset) begin
         r_page <= 8'h00;
         r_base <= 8'h00;
      end else if ((r_state == ST_IDLE) && i_trig) begin
         r_page <= i_page;
         r_base <= i_oam_base;
      end
   end

   // Registered outputs, decoded from the state being entered so they line
   // up with the state register. Data is sampled at the edge closing READ.
   always_ff @(posedge i_clk_cpu or posedge i_reset) begin
      if (i_reset) begin
         r_rdy      <= 1'b1;
         r_busy     <= 1'b0;
         r_bus_ce   <= 1'b0;
         r_bus_addr <= '0;
         r_oam_we   <= 1'b0;
         r_oam_addr <= 8'h00;
         r_oam_data <= 8'h00;
      end else begin
         r_rdy    <= (w_state_nxt == ST_IDLE);
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_bus_ce <= (w_state_nxt == ST_READ);
         r_oam_we <= (w_state_nxt == ST_WRITE);
         if (w_state_nxt == ST_READ) r_bus_addr <= ADDR_W'({r_page, w_idx_nxt});
         if (w_state_nxt == ST_WRITE) begin
            r_oam_addr <= r_base + 8'(r_idx);
            r_oam_data <= i_bus_data;
         end
      end
   end

   assign o_rdy      = r_rdy;
   assign o_busy     = r_busy;
   assign o_bus_ce   = r_bus_ce;
   assign o_bus_rnw  = 1'b1;
   assign o_bus_addr = r_bus_addr;
   assign o_oam_we   = r_oam_we;
   assign o_oam_addr = r_oam_addr;
   assign o_oam_data = r_oam_data;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table of full transfers plus
// hand-written sequences for re-trigger, trigger-at-end, reset and abort.
module tb_oam_dma_ctrl;

   logic        i_clk_cpu = 1'b0;
   logic        i_reset   = 1'b1;
   logic        i_trig    = 1'b0;
   logic [7:0]  i_page    = 8'h00;
   logic [7:0]  i_oam_base = 8'h00;
   logic        i_abort   = 1'b0;
   logic        o_rdy, o_busy, o_bus_ce, o_bus_rnw, o_oam_we;
   logic [15:0] o_bus_addr;
   logic [7:0]  i_bus_data = 8'h00;
   logic [7:0]  o_oam_addr, o_oam_data;

   oam_dma_ctrl dut (
      .i_clk_cpu  (i_clk_cpu),
      .i_reset    (i_reset),
      .i_trig     (i_trig),
      .i_page     (i_page),
      .i_oam_base (i_oam_base),
`ifdef OAM_DMA_ABORT_EN
      .i_abort    (i_abort),
`endif
      .o_rdy      (o_rdy),
      .o_busy     (o_busy),
      .o_bus_ce   (o_bus_ce),
      .o_bus_rnw  (o_bus_rnw),
      .o_bus_addr (o_bus_addr),
      .i_bus_data (i_bus_data),
      .o_oam_we   (o_oam_we),
      .o_oam_addr (o_oam_addr),
      .o_oam_data (o_oam_data)
   );

   always #5 i_clk_cpu = ~i_clk_cpu;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bench view of the get/put phase: toggles on every edge out of reset.
   logic tb_par;
   always @(posedge i_clk_cpu or posedge i_reset) begin
      if (i_reset) tb_par <= 1'b0;
      else         tb_par <= ~tb_par;
   end

   // CPU RAM and OAM models plus transfer statistics, sampled mid-cycle.
   logic [7:0]  mem [0:65535];
   logic [7:0]  oam [0:255];
   int          low_cnt, rd_cnt, bad_rd, wr_cnt, busy_pulses;
   logic [15:0] max_addr;
   logic [7:0]  exp_page, first_addr, last_addr, first_data;
   logic        busy_q;

   always @(negedge i_clk_cpu) begin
      i_bus_data = o_bus_ce ? mem[o_bus_addr] : 8'h00;
      if (!i_reset) begin
         if (!o_rdy) low_cnt++;
         if (o_busy && !busy_q) busy_pulses++;
         busy_q = o_busy;
         if (o_bus_ce) begin
            rd_cnt++;
            if (o_bus_addr[15:8] != exp_page) bad_rd++;
            if (o_bus_addr > max_addr) max_addr = o_bus_addr;
         end
         if (o_oam_we) begin
            oam[o_oam_addr] = o_oam_data;
            if (wr_cnt == 0) begin
               first_addr = o_oam_addr;
               first_data = o_oam_data;
            end
            last_addr = o_oam_addr;
            wr_cnt++;
         end
      end
   end

   task automatic clr_stats(input logic [7:0] page);
      low_cnt = 0; rd_cnt = 0; bad_rd = 0; wr_cnt = 0; busy_pulses = 0;
      max_addr = 16'h0000; busy_q = 1'b0; exp_page = page;
      for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
   endtask

   // One-cycle trigger, placed on a cycle whose phase equals par.
   task automatic pulse_trig(input logic [7:0] page, input logic [7:0] base, input logic par);
      @(posedge i_clk_cpu); #1;
      if (tb_par != par) begin
         @(posedge i_clk_cpu); #1;
      end
      i_trig = 1'b1; i_page = page; i_oam_base = base;
      @(posedge i_clk_cpu); #1;
      i_trig = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (o_busy && n < 700) begin
         @(posedge i_clk_cpu); #1;
         n++;
      end
      check({name, "_timeout"}, 32'(n < 700), 32'd1);
      @(posedge i_clk_cpu); #1;
   endtask

   task automatic wait_wr(input int target, input string name);
      int n = 0;
      while (wr_cnt != target && n < 700) begin
         @(posedge i_clk_cpu); #1;
         n++;
      end
      check({name, "_wr_timeout"}, 32'(n < 700), 32'd1);
   endtask

   task automatic check_data(input string name, input logic [7:0] base, input logic [7:0] key);
      int bad = 0;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) begin
         a = base + 8'(i);
         if (oam[a] !== (8'(i) ^ key)) bad++;
      end
      check({name, "_data_mism"}, 32'(bad), 32'd0);
   endtask

   typedef struct {
      logic [7:0] page;
      logic [7:0] base;
      logic       par;
      logic [7:0] key;
      int         exp_low;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{8'h02, 8'h00, 1'b0, 8'hA5, 513, 8'h00, 8'hFF};
      vecs[1] = '{8'h02, 8'h00, 1'b1, 8'hA5, 514, 8'h00, 8'hFF};
      vecs[2] = '{8'h03, 8'hFE, 1'b0, 8'h3C, 513, 8'hFE, 8'hFD};
      vecs[3] = '{8'h05, 8'h80, 1'b1, 8'h77, 514, 8'h80, 8'h7F};

      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
         mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'h3C;
         mem[{8'h05, 8'(i)}] = 8'(i) ^ 8'h77;
      end
      clr_stats(8'h00);

      // Reset values, observed while reset is still held.
      #12;
      check("rst_rdy",      32'(o_rdy),      32'd1);
      check("rst_busy",     32'(o_busy),     32'd0);
      check("rst_ce",       32'(o_bus_ce),   32'd0);
      check("rst_rnw",      32'(o_bus_rnw),  32'd1);
      check("rst_addr",     32'(o_bus_addr), 32'd0);
      check("rst_we",       32'(o_oam_we),   32'd0);
      check("rst_oam_addr", 32'(o_oam_addr), 32'd0);
      check("rst_oam_data", 32'(o_oam_data), 32'd0);
      #11 i_reset = 1'b0;

      // Full transfers from the vector table.
      for (int v = 0; v < 4; v++) begin
         clr_stats(vecs[v].page);
         pulse_trig(vecs[v].page, vecs[v].base, vecs[v].par);
         wait_done($sformatf("v%0d", v));
         check($sformatf("v%0d_rdy_low", v),  32'(low_cnt),     32'(vecs[v].exp_low));
         check($sformatf("v%0d_writes", v),   32'(wr_cnt),      32'd256);
         check($sformatf("v%0d_reads", v),    32'(rd_cnt),      32'd256);
         check($sformatf("v%0d_bad_page", v), 32'(bad_rd),      32'd0);
         check($sformatf("v%0d_max_addr", v), 32'(max_addr),    32'({vecs[v].page, 8'hFF}));
         check($sformatf("v%0d_first", v),    32'(first_addr),  32'(vecs[v].exp_first));
         check($sformatf("v%0d_first_d", v),  32'(first_data),  32'(vecs[v].key));
         check($sformatf("v%0d_last", v),     32'(last_addr),   32'(vecs[v].exp_last));
         check($sformatf("v%0d_busy_pulse", v), 32'(busy_pulses), 32'd1);
         check($sformatf("v%0d_idle_rdy", v), 32'(o_rdy),       32'd1);
         check_data($sformatf("v%0d", v), vecs[v].base, vecs[v].key);
      end

      // Re-trigger with another page 100 cycles in: must be ignored.
      clr_stats(8'h02);
      pulse_trig(8'h02, 8'h00, 1'b0);
      repeat (100) @(posedge i_clk_cpu);
      #1 i_trig = 1'b1; i_page = 8'h05; i_oam_base = 8'h40;
      @(posedge i_clk_cpu); #1 i_trig = 1'b0;
      wait_done("retrig");
      check("retrig_bad_page", 32'(bad_rd),      32'd0);
      check("retrig_reads",    32'(rd_cnt),      32'd256);
      check("retrig_pulses",   32'(busy_pulses), 32'd1);
      check("retrig_rdy_low",  32'(low_cnt),     32'd513);
      check_data("retrig", 8'h00, 8'hA5);

      // Trigger coinciding with the final WRITE: no new transfer.
      clr_stats(8'h03);
      pulse_trig(8'h03, 8'h10, 1'b1);
      wait_wr(255, "lastw");
      @(posedge i_clk_cpu); #1;
      check("lastw_we",   32'(o_oam_we),   32'd1);
      check("lastw_addr", 32'(o_oam_addr), 32'h0F);
      i_trig = 1'b1; i_page = 8'h05;
      @(posedge i_clk_cpu); #1 i_trig = 1'b0;
      check("lastw_rdy",  32'(o_rdy),  32'd1);
      repeat (5) @(posedge i_clk_cpu);
      #1;
      check("lastw_busy", 32'(o_busy), 32'd0);
      check("lastw_pulses", 32'(busy_pulses), 32'd1);

      // Reset during write #40: strobe dropped at once, nothing afterwards.
      clr_stats(8'h02);
      pulse_trig(8'h02, 8'h00, 1'b0);
      wait_wr(39, "rst40");
      @(posedge i_clk_cpu); #1;
      check("rst40_pre_we", 32'(o_oam_we), 32'd1);
      i_reset = 1'b1;
      #1;
      check("rst40_rdy",  32'(o_rdy),    32'd1);
      check("rst40_we",   32'(o_oam_we), 32'd0);
      check("rst40_busy", 32'(o_busy),   32'd0);
      repeat (2) @(posedge i_clk_cpu);
      #1 i_reset = 1'b0;
      repeat (20) @(posedge i_clk_cpu);
      #1;
      check("rst40_writes", 32'(wr_cnt), 32'd39);
      check("rst40_idle",   32'(o_busy), 32'd0);
      check("rst40_oam39",  32'(oam[39]), 32'hEE);

`ifdef OAM_DMA_ABORT_EN
      // Abort raised while byte 10 is being read: its write never happens.
      clr_stats(8'h02);
      pulse_trig(8'h02, 8'h00, 1'b0);
      wait_wr(10, "abort");
      i_abort = 1'b1;
      @(posedge i_clk_cpu); #1 i_abort = 1'b0;
      check("abort_rdy",  32'(o_rdy),    32'd1);
      check("abort_we",   32'(o_oam_we), 32'd0);
      check("abort_busy", 32'(o_busy),   32'd0);
      repeat (10) @(posedge i_clk_cpu);
      #1;
      check("abort_writes", 32'(wr_cnt),  32'd10);
      check("abort_oam9",   32'(oam[9]),  32'(8'd9 ^ 8'hA5));
      check("abort_oam10",  32'(oam[10]), 32'hEE);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
